// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge: FSM states, region decode,
// default MMIO timeout/error data, lane masks and a saturating-increment helper.
package dmem_bridge_pkg;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_IO_WAIT = 1'b1
    } state_t;

    localparam int          MMIO_SEL_BIT    = 31;
    localparam int          IO_TIMEOUT_DEF  = 255;
    localparam logic [31:0] IO_ERR_DATA_DEF = 32'hDEADBEEF;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Bus bundle between the core/RAM/MMIO environment (master) and the bridge (slave).
interface dmem_bridge_if #(
    parameter int RAM_SCALE = 14
);
    logic [31:0]          cpu_addr;
    logic [3:0]           cpu_oe;
    logic [31:0]          cpu_wdata;
    logic [3:0]           cpu_we;
    logic [31:0]          cpu_rdata;
    logic                 cpu_valid;
    logic                 cpu_ready;
    logic [RAM_SCALE-1:0] ram_addr;
    logic                 ram_oe;
    logic [3:0]           ram_we;
    logic [31:0]          ram_wdata;
    logic [31:0]          ram_rdata;
    logic                 io_req;
    logic [31:0]          io_addr;
    logic [3:0]           io_we;
    logic [31:0]          io_wdata;
    logic                 io_ack;
    logic [31:0]          io_rdata;
    logic                 err;

    modport master (
        output cpu_addr, cpu_oe, cpu_wdata, cpu_we, ram_rdata, io_ack, io_rdata,
        input  cpu_rdata, cpu_valid, cpu_ready, ram_addr, ram_oe, ram_we, ram_wdata,
               io_req, io_addr, io_we, io_wdata, err
    );

    modport slave (
        input  cpu_addr, cpu_oe, cpu_wdata, cpu_we, ram_rdata, io_ack, io_rdata,
        output cpu_rdata, cpu_valid, cpu_ready, ram_addr, ram_oe, ram_we, ram_wdata,
               io_req, io_addr, io_we, io_wdata, err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane aligner: store-side left shift with misalign detect,
// load-side right shift with zero-fill above the access width.
module dmem_lane_align (
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_mask,
    input  logic [3:0]  i_we,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_we,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_lanes;
    logic [4:0]  w_sh;
    logic [31:0] w_rsh;
    logic [31:0] w_bmask;

    assign w_sh       = {i_off, 3'b000};
    assign w_lanes    = {4'h0, i_mask} << i_off;
    // Any lane pushed past bit 3 would straddle a word boundary.
    assign o_misalign = (w_lanes > 8'h0F);
    assign o_we       = i_we << i_off;
    assign o_wdata    = i_wdata << w_sh;

    assign w_rsh   = i_rdata >> w_sh;
    assign w_bmask = {{8{i_mask[3]}}, {8{i_mask[2]}}, {8{i_mask[1]}}, {8{i_mask[0]}}};
    assign o_rdata = w_rsh & w_bmask;
endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: decodes core requests to data RAM or MMIO, aligns byte lanes.
// Optional statistics counters enabled by defining DMEM_BRIDGE_STAT_EN.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int          RAM_SCALE   = 14,
    parameter int          IO_TIMEOUT  = IO_TIMEOUT_DEF,
    parameter logic [31:0] IO_ERR_DATA = IO_ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    dmem_bridge_if.slave bus,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_io_wait_cycles,
    output logic [31:0] stat_timeouts
);
    localparam int TW = $clog2(IO_TIMEOUT + 2);

    state_t        r_state, w_state_nx;
    logic          r_ready, r_io_req, r_err, r_io_load;
    logic [31:0]   r_io_addr, r_io_wdata, r_io_rd;
    logic [3:0]    r_io_we, r_mask;
    logic [1:0]    r_off;
    logic [TW-1:0] r_timer;
    logic          r_rsp_vld, r_rsp_io, r_rsp_err;

    logic          w_accept, w_store, w_mmio, w_mis, w_ram_ld, w_ram_st, w_io_go;
    logic          w_io_done, w_io_tmo;
    logic [3:0]    w_we_sh;
    logic [31:0]   w_wdata_sh, w_rsp_src, w_rsp_data;
    logic [31:0]   w_unused_req_rd, w_unused_rsp_wd;
    logic [3:0]    w_unused_rsp_we;
    logic          w_unused_rsp_mis;

    assign w_accept = (|bus.cpu_oe) && r_ready && !rst;
    assign w_store  = |bus.cpu_we;
    assign w_mmio   = bus.cpu_addr[MMIO_SEL_BIT];
    assign w_ram_ld = w_accept && !w_store && !w_mmio && !w_mis;
    assign w_ram_st = w_accept && w_store && !w_mmio && !w_mis;
    assign w_io_go  = w_accept && w_mmio && !w_mis;

    dmem_lane_align u_req (
        .i_off(bus.cpu_addr[1:0]), .i_mask(bus.cpu_oe), .i_we(bus.cpu_we),
        .i_wdata(bus.cpu_wdata), .i_rdata(32'h0),
        .o_we(w_we_sh), .o_wdata(w_wdata_sh), .o_misalign(w_mis), .o_rdata(w_unused_req_rd)
    );

    assign w_rsp_src = r_rsp_io ? r_io_rd : bus.ram_rdata;

    dmem_lane_align u_rsp (
        .i_off(r_off), .i_mask(r_mask), .i_we(4'h0), .i_wdata(32'h0), .i_rdata(w_rsp_src),
        .o_we(w_unused_rsp_we), .o_wdata(w_unused_rsp_wd), .o_misalign(w_unused_rsp_mis),
        .o_rdata(w_rsp_data)
    );

    assign bus.ram_addr  = bus.cpu_addr[2 +: RAM_SCALE];
    assign bus.ram_oe    = w_ram_ld;
    assign bus.ram_we    = w_ram_st ? w_we_sh : 4'h0;
    assign bus.ram_wdata = w_ram_st ? w_wdata_sh : 32'h0;
    assign bus.cpu_valid = r_rsp_vld;
    assign bus.cpu_rdata = !r_rsp_vld ? 32'h0 : (r_rsp_err ? IO_ERR_DATA : w_rsp_data);
    assign bus.cpu_ready = r_ready;
    assign bus.io_req    = r_io_req;
    assign bus.io_addr   = r_io_addr;
    assign bus.io_we     = r_io_we;
    assign bus.io_wdata  = r_io_wdata;
    assign bus.err       = r_err;

    always_comb begin
        w_state_nx = r_state;
        w_io_done  = 1'b0;
        w_io_tmo   = 1'b0;
        case (r_state)
            S_IDLE: if (w_io_go) w_state_nx = S_IO_WAIT;
            S_IO_WAIT: begin
                // An ack landing on the timeout cycle takes priority over the abort.
                if (bus.io_ack) begin
                    w_io_done = 1'b1;
                end else if (r_timer == TW'(IO_TIMEOUT)) begin
                    w_io_done = 1'b1;
                    w_io_tmo  = 1'b1;
                end
                if (w_io_done) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready    <= 1'b1;
            r_io_req   <= 1'b0;
            r_err      <= 1'b0;
            r_io_load  <= 1'b0;
            r_io_addr  <= '0;
            r_io_wdata <= '0;
            r_io_we    <= '0;
            r_io_rd    <= '0;
            r_off      <= '0;
            r_mask     <= '0;
            r_timer    <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_io   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_rsp_vld <= 1'b0;
            r_rsp_io  <= 1'b0;
            r_rsp_err <= 1'b0;
            if (w_accept && w_mis) r_err <= 1'b1;
            // RAM loads and misaligned loads both answer on the following cycle.
            if (w_accept && !w_store && (!w_mmio || w_mis)) begin
                r_rsp_vld <= 1'b1;
                r_rsp_err <= w_mis;
                r_off     <= bus.cpu_addr[1:0];
                r_mask    <= bus.cpu_oe;
            end
            if (w_io_go) begin
                r_io_addr  <= {bus.cpu_addr[31:2], 2'b00};
                r_io_we    <= w_store ? w_we_sh : 4'h0;
                r_io_wdata <= w_wdata_sh;
                r_io_load  <= !w_store;
                r_off      <= bus.cpu_addr[1:0];
                r_mask     <= bus.cpu_oe;
                r_io_req   <= 1'b1;
                r_ready    <= 1'b0;
                r_timer    <= '0;
            end
            if (r_state == S_IO_WAIT) begin
                if (w_io_done) begin
                    r_io_req  <= 1'b0;
                    r_ready   <= 1'b1;
                    r_rsp_vld <= r_io_load;
                    r_rsp_io  <= 1'b1;
                    r_rsp_err <= w_io_tmo;
                    r_io_rd   <= bus.io_rdata;
                    if (w_io_tmo) r_err <= 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

`ifdef DMEM_BRIDGE_STAT_EN
    logic [31:0] r_st_ld, r_st_st, r_st_wait, r_st_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st_ld   <= '0;
            r_st_st   <= '0;
            r_st_wait <= '0;
            r_st_tmo  <= '0;
        end else begin
            r_st_ld   <= sat_inc(r_st_ld, w_accept && !w_store);
            r_st_st   <= sat_inc(r_st_st, w_accept && w_store);
            r_st_wait <= sat_inc(r_st_wait, r_state == S_IO_WAIT);
            r_st_tmo  <= sat_inc(r_st_tmo, w_io_tmo);
        end
    end

    assign stat_loads          = r_st_ld;
    assign stat_stores         = r_st_st;
    assign stat_io_wait_cycles = r_st_wait;
    assign stat_timeouts       = r_st_tmo;
`else
    assign stat_loads          = '0;
    assign stat_stores         = '0;
    assign stat_io_wait_cycles = '0;
    assign stat_timeouts       = '0;
`endif
endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: table of single RAM accesses plus hand-built MMIO,
// timeout, misalignment and reset sequences.
module tb_dmem_bridge;
    import dmem_bridge_pkg::*;

    logic        clk, rst;
    logic [31:0] stat_loads, stat_stores, stat_io_wait_cycles, stat_timeouts;
    int          n_tests = 0;
    int          n_fail  = 0;

    dmem_bridge_if #(.RAM_SCALE(14)) bus ();

    dmem_bridge #(.RAM_SCALE(14), .IO_TIMEOUT(255), .IO_ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .stat_loads(stat_loads), .stat_stores(stat_stores),
        .stat_io_wait_cycles(stat_io_wait_cycles), .stat_timeouts(stat_timeouts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  oe;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [13:0] e_addr;
        logic        e_oe;
        logic [3:0]  e_we;
        logic [31:0] e_wdata;
        logic        e_vld;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] oe, input logic [3:0] we,
                         input logic [31:0] wd);
        bus.cpu_addr  = a;
        bus.cpu_oe    = oe;
        bus.cpu_we    = we;
        bus.cpu_wdata = wd;
    endtask

    task automatic idle_req();
        drive(32'h0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic io_timeout_run(input logic ack_at_to);
        step();
        drive(32'h8000_0040, LANE_W, 4'h0, 32'h0);
        step();
        idle_req();
        repeat (255) step();
        if (ack_at_to) begin
            bus.io_ack   = 1'b1;
            bus.io_rdata = 32'h0BAD_F00D;
        end
        @(negedge clk);
        chk("to io_req held at limit", {31'h0, bus.io_req}, 32'h1);
        chk("to err before limit", {31'h0, bus.err}, 32'h0);
        step();
        bus.io_ack   = 1'b0;
        bus.io_rdata = 32'h0;
        @(negedge clk);
        chk("to io_req dropped", {31'h0, bus.io_req}, 32'h0);
        chk("to cpu_ready back", {31'h0, bus.cpu_ready}, 32'h1);
        chk("to cpu_valid", {31'h0, bus.cpu_valid}, 32'h1);
        chk("to cpu_rdata", bus.cpu_rdata, ack_at_to ? 32'h0BAD_F00D : 32'hDEAD_BEEF);
        chk("to err", {31'h0, bus.err}, ack_at_to ? 32'h0 : 32'h1);
    endtask

    initial begin
        vt[0] = '{32'h103,   4'h1, 4'h1, 32'hAB,       32'h0,        14'h40,   1'b0, 4'h8, 32'hAB00_0000, 1'b0, 32'h0};
        vt[1] = '{32'h202,   4'h3, 4'h3, 32'hBEEF,     32'h0,        14'h80,   1'b0, 4'hC, 32'hBEEF_0000, 1'b0, 32'h0};
        vt[2] = '{32'h10,    4'hF, 4'hF, 32'h1122_3344, 32'h0,       14'h4,    1'b0, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
        vt[3] = '{32'h1,     4'h1, 4'h1, 32'h5A,       32'h0,        14'h0,    1'b0, 4'h2, 32'h0000_5A00, 1'b0, 32'h0};
        vt[4] = '{32'h3FFFC, 4'hF, 4'h0, 32'h0,        32'hA5A5_1234, 14'h3FFF, 1'b1, 4'h0, 32'h0,        1'b1, 32'hA5A5_1234};
        vt[5] = '{32'h10007, 4'h1, 4'h0, 32'h0,        32'h1234_5678, 14'h1,    1'b1, 4'h0, 32'h0,        1'b1, 32'h12};
        vt[6] = '{32'h100,   4'h3, 4'h0, 32'h0,        32'h1234_5678, 14'h40,   1'b1, 4'h0, 32'h0,        1'b1, 32'h5678};
        vt[7] = '{32'h102,   4'h1, 4'h0, 32'h0,        32'h89AB_CDEF, 14'h40,   1'b1, 4'h0, 32'h0,        1'b1, 32'hAB};

        rst = 1'b1;
        idle_req();
        bus.ram_rdata = 32'h0;
        bus.io_ack    = 1'b0;
        bus.io_rdata  = 32'h0;
        @(negedge clk);
        chk("reset cpu_ready", {31'h0, bus.cpu_ready}, 32'h1);
        chk("reset io_req", {31'h0, bus.io_req}, 32'h0);
        chk("reset err", {31'h0, bus.err}, 32'h0);
        chk("reset cpu_valid", {31'h0, bus.cpu_valid}, 32'h0);
        chk("reset io_addr", bus.io_addr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            step();
            drive(vt[i].addr, vt[i].oe, vt[i].we, vt[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d ram_addr", i), {18'h0, bus.ram_addr}, {18'h0, vt[i].e_addr});
            chk($sformatf("v%0d ram_oe", i), {31'h0, bus.ram_oe}, {31'h0, vt[i].e_oe});
            chk($sformatf("v%0d ram_we", i), {28'h0, bus.ram_we}, {28'h0, vt[i].e_we});
            chk($sformatf("v%0d ram_wdata", i), bus.ram_wdata, vt[i].e_wdata);
            step();
            idle_req();
            bus.ram_rdata = vt[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d cpu_valid", i), {31'h0, bus.cpu_valid}, {31'h0, vt[i].e_vld});
            chk($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata, vt[i].e_rdata);
            chk($sformatf("v%0d io_req", i), {31'h0, bus.io_req}, 32'h0);
        end
        bus.ram_rdata = 32'h0;

        // LH then back-to-back LW while the first result returns
        step();
        drive(32'h102, LANE_H, 4'h0, 32'h0);
        step();
        drive(32'h104, LANE_W, 4'h0, 32'h0);
        bus.ram_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("b2b lh valid", {31'h0, bus.cpu_valid}, 32'h1);
        chk("b2b lh rdata", bus.cpu_rdata, 32'h0000_1234);
        chk("b2b lw ram_oe", {31'h0, bus.ram_oe}, 32'h1);
        chk("b2b lw ram_addr", {18'h0, bus.ram_addr}, 32'h41);
        step();
        idle_req();
        bus.ram_rdata = 32'hFEED_FACE;
        @(negedge clk);
        chk("b2b lw valid", {31'h0, bus.cpu_valid}, 32'h1);
        chk("b2b lw rdata", bus.cpu_rdata, 32'hFEED_FACE);
        step();
        bus.ram_rdata = 32'h0;
        @(negedge clk);
        chk("b2b idle valid", {31'h0, bus.cpu_valid}, 32'h0);

        // MMIO word load, ack on third wait cycle
        step();
        drive(32'h8000_0010, LANE_W, 4'h0, 32'h0);
        @(negedge clk);
        chk("io lw accept io_req", {31'h0, bus.io_req}, 32'h0);
        chk("io lw accept ram_oe", {31'h0, bus.ram_oe}, 32'h0);
        step();
        idle_req();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                bus.io_ack   = 1'b1;
                bus.io_rdata = 32'hCAFE_F00D;
            end
            @(negedge clk);
            chk($sformatf("io lw c%0d io_req", c), {31'h0, bus.io_req}, 32'h1);
            chk($sformatf("io lw c%0d cpu_ready", c), {31'h0, bus.cpu_ready}, 32'h0);
            if (c < 3) step();
        end
        chk("io lw io_addr", bus.io_addr, 32'h8000_0010);
        step();
        bus.io_ack   = 1'b0;
        bus.io_rdata = 32'h0;
        @(negedge clk);
        chk("io lw done io_req", {31'h0, bus.io_req}, 32'h0);
        chk("io lw done cpu_ready", {31'h0, bus.cpu_ready}, 32'h1);
        chk("io lw valid", {31'h0, bus.cpu_valid}, 32'h1);
        chk("io lw rdata", bus.cpu_rdata, 32'hCAFE_F00D);

        // MMIO halfword store
        step();
        drive(32'h8000_0022, LANE_H, LANE_H, 32'h1234);
        step();
        idle_req();
        bus.io_ack = 1'b1;
        @(negedge clk);
        chk("io sh io_addr", bus.io_addr, 32'h8000_0020);
        chk("io sh io_we", {28'h0, bus.io_we}, 32'hC);
        chk("io sh io_wdata", bus.io_wdata, 32'h1234_0000);
        step();
        bus.io_ack = 1'b0;
        @(negedge clk);
        chk("io sh no valid", {31'h0, bus.cpu_valid}, 32'h0);
        chk("io sh cpu_ready", {31'h0, bus.cpu_ready}, 32'h1);

        // MMIO byte load at offset 1
        step();
        drive(32'h8000_0001, LANE_B, 4'h0, 32'h0);
        step();
        idle_req();
        bus.io_ack   = 1'b1;
        bus.io_rdata = 32'h0000_AB00;
        step();
        bus.io_ack   = 1'b0;
        bus.io_rdata = 32'h0;
        @(negedge clk);
        chk("io lb valid", {31'h0, bus.cpu_valid}, 32'h1);
        chk("io lb rdata", bus.cpu_rdata, 32'h0000_00AB);

        // Stray ack in IDLE
        step();
        bus.io_ack   = 1'b1;
        bus.io_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("idle ack io_req", {31'h0, bus.io_req}, 32'h0);
        step();
        bus.io_ack   = 1'b0;
        bus.io_rdata = 32'h0;
        @(negedge clk);
        chk("idle ack no valid", {31'h0, bus.cpu_valid}, 32'h0);
        chk("idle ack cpu_ready", {31'h0, bus.cpu_ready}, 32'h1);

        io_timeout_run(1'b1);
        io_timeout_run(1'b0);

        // Reset in the middle of an MMIO wait
        step();
        drive(32'h8000_0080, LANE_W, 4'h0, 32'h0);
        step();
        idle_req();
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst io_req", {31'h0, bus.io_req}, 32'h0);
        chk("midrst cpu_ready", {31'h0, bus.cpu_ready}, 32'h1);
        chk("midrst err cleared", {31'h0, bus.err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst no valid", {31'h0, bus.cpu_valid}, 32'h0);
        step();
        @(negedge clk);
        chk("midrst still no valid", {31'h0, bus.cpu_valid}, 32'h0);

        // Misaligned store, load, and MMIO load
        step();
        drive(32'h2, LANE_W, LANE_W, 32'h1111_2222);
        @(negedge clk);
        chk("mis sw ram_we", {28'h0, bus.ram_we}, 32'h0);
        step();
        idle_req();
        @(negedge clk);
        chk("mis sw err", {31'h0, bus.err}, 32'h1);
        chk("mis sw io_req", {31'h0, bus.io_req}, 32'h0);
        chk("mis sw no valid", {31'h0, bus.cpu_valid}, 32'h0);
        step();
        drive(32'h3, LANE_H, 4'h0, 32'h0);
        @(negedge clk);
        chk("mis lh ram_oe", {31'h0, bus.ram_oe}, 32'h0);
        step();
        idle_req();
        bus.ram_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("mis lh valid", {31'h0, bus.cpu_valid}, 32'h1);
        chk("mis lh rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        step();
        bus.ram_rdata = 32'h0;
        drive(32'h8000_0002, LANE_W, 4'h0, 32'h0);
        step();
        idle_req();
        @(negedge clk);
        chk("mis io io_req", {31'h0, bus.io_req}, 32'h0);
        chk("mis io cpu_ready", {31'h0, bus.cpu_ready}, 32'h1);
        chk("mis io rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        chk("mis err sticky", {31'h0, bus.err}, 32'h1);

`ifndef DMEM_BRIDGE_STAT_EN
        chk("stats tied off", stat_loads | stat_stores | stat_io_wait_cycles | stat_timeouts, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory bridge directly downstream of the processor's execute/memory stage.
- Consumes the core's byte-lane memory request (addr, oe, wdata, we) and decodes it to on-chip data RAM or the MMIO bus.
- Performs byte-lane alignment and returns right-aligned read data with valid/ready handshaking, so the core's load-extend logic and stall logic work unchanged.

Parameters:
- RAM_SCALE, 14, word-address bits of the data RAM (RAM = 2^RAM_SCALE words).
- IO_TIMEOUT, 255, cycles to wait for io_ack before an MMIO access is aborted.
- IO_ERR_DATA, 32'hDEADBEEF, read data returned on an MMIO timeout or a misaligned load.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cpu_addr  in  32  byte address
- cpu_oe  in  4  lane-access mask, right-aligned (0001=byte, 0011=half, 1111=word); nonzero = request
- cpu_wdata  in  32  store data, right-aligned
- cpu_we  in  4  store lane mask, right-aligned; nonzero = store
- cpu_rdata  out  32  load data, right-aligned, zero-filled above access width
- cpu_valid  out  1  one-cycle pulse: cpu_rdata valid for the last load
- cpu_ready  out  1  bridge can accept a request this cycle
- ram_addr  out  RAM_SCALE  RAM word address
- ram_oe  out  1  RAM read enable
- ram_we  out  4  RAM byte write enables (shifted)
- ram_wdata  out  32  RAM write data (shifted)
- ram_rdata  in  32  RAM read data, one-cycle latency after ram_oe
- io_req  out  1  MMIO request, held until io_ack
- io_addr  out  32  MMIO address, word-aligned
- io_we  out  4  MMIO byte write enables (shifted)
- io_wdata  out  32  MMIO write data (shifted)
- io_ack  in  1  MMIO completion
- io_rdata  in  32  MMIO read data, valid with io_ack
- err  out  1  sticky error: misalignment or MMIO timeout

Behaviour:
- Reset: clk and rst as stated; reset is asynchronous and active-high. All outputs clear to 0 except cpu_ready=1. State=IDLE, timer=0, err=0.
- Accept: accept when |cpu_oe && cpu_ready. Store if |cpu_we, else load. cpu_addr[31]=0 selects RAM; cpu_addr[31]=1 selects MMIO.
- Alignment: off=cpu_addr[1:0].
  - Shifted lanes = cpu_oe<<off. Shifted data = cpu_wdata<<(8*off).
  - Misaligned when any shifted lane exceeds bit 3 (e.g., word at off≠0, half at off=3).
  - Misaligned access: no RAM/IO strobe, err<=1. A load still gets cpu_valid next cycle with IO_ERR_DATA.
- RAM path (no state change, cpu_ready stays 1, back-to-back accepts allowed):
  - ram_addr = cpu_addr[2+:RAM_SCALE], combinational from request.
  - Load: ram_oe=1; off and lane mask registered. Next cycle cpu_valid=1, cpu_rdata=(ram_rdata>>8*off_q) masked to access width.
  - Store: ram_we = shifted lanes, same cycle; no cpu_valid.
- MMIO FSM, IDLE -> IO_WAIT -> IDLE:
  - On accept: register io_addr={addr[31:2],2'b00}, io_we, io_wdata, off, mask; io_req<=1; cpu_ready<=0 (registered, low from the next cycle).
  - IO_WAIT: io_req held; timer increments each cycle.
  - io_ack=1: io_req<=0, cpu_ready<=1, ->IDLE. If load: cpu_valid pulse with io_rdata aligned as in the RAM path.
  - timer==IO_TIMEOUT with no ack: abort exactly as on ack, but data=IO_ERR_DATA and err<=1.
  - io_ack in the same cycle as the timeout: ack wins, no error.
  - io_ack while IDLE: ignored.
- Simultaneous events: a RAM load result (cpu_valid) and a new accept in the same cycle are legal. A request in the accept cycle of an MMIO access is impossible because cpu_ready is low from the next cycle.
- Reset mid-transaction: io_req drops immediately, state IDLE, no cpu_valid generated.
- err clears only on reset.

Optional Feature:
- DMEM_BRIDGE_STAT_EN defined: adds 32-bit saturating counters stat_loads, stat_stores, stat_io_wait_cycles and stat_timeouts, exposed as output ports of the same names. Counters clear on reset.
- Undefined: those ports still exist, tied to 0; no counter logic.

Decomposition:
- Shared package holds:
  - FSM state encodings (S_IDLE, S_IO_WAIT)
  - region decode constant (MMIO_SEL_BIT=31)
  - default IO_TIMEOUT and IO_ERR_DATA
  - lane-mask constants (LANE_B=4'b0001, LANE_H=4'b0011, LANE_W=4'b1111)
- One sub-module, dmem_lane_align: purely combinational. Store-side shift plus misalign detect, and load-side right-shift plus width mask. Instantiated twice (request side, response side).

Test Plan:
- SB addr=0x103 wdata=0x000000AB -> ram_addr=0x40, ram_we=1000, ram_wdata=0xAB000000, err=0.
- LH addr=0x102 with ram_rdata=0x1234_5678 -> cpu_valid next cycle, cpu_rdata=0x00001234; back-to-back LW addr=0x104 accepted the same cycle.
- LW addr=0x8000_0010, io_ack after 3 cycles with io_rdata=0xCAFEF00D:
  - cpu_ready low for 3 cycles, io_req held 3 cycles;
  - cpu_valid with cpu_rdata=0xCAFEF00D;
  - cpu_ready=1 the cycle after ack.
- LW to MMIO with no ack -> abort after IO_TIMEOUT=255 cycles, cpu_valid with 0xDEADBEEF, err=1; io_ack arriving in the timeout cycle -> normal data, err=0.
- SW addr=0x2 -> no ram_we, no io_req, err=1; rst asserted during IO_WAIT -> io_req=0 and cpu_ready=1 immediately, no cpu_valid.
